// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and helpers shared by the sequential ALU
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;
  localparam logic [2:0] OP_GT  = 3'd6;
  localparam logic [2:0] OP_LT  = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_DONE} state_t;
  function automatic logic is_divop(input logic [2:0] op);
    return op == OP_DIV || op == OP_MOD;
  endfunction
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: valid/ready operand and result channels of the sequential ALU
interface seq_alu_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0] opcode;
  logic out_valid;
  logic out_ready;
  logic [2*WIDTH-1:0] result;
  logic div_zero;
  logic zero;
  modport master(output in_valid, a, b, opcode, out_ready,
                 input in_ready, out_valid, result, div_zero, zero);
  modport slave(input in_valid, a, b, opcode, out_ready,
                output in_ready, out_valid, result, div_zero, zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock over WIDTH clocks
module seq_divider #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic busy,
  output logic done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] count;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [WIDTH:0] trial, diff;
  logic qbit;
  assign trial = {rem, dvd[WIDTH-1]};
  assign diff = trial - {1'b0, dvs};
  assign qbit = trial >= {1'b0, dvs};
  // quotient/remainder are the post-step values, final when the last step runs
  assign quotient = {dvd[WIDTH-2:0], qbit};
  assign remainder = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign busy = count != '0;
  assign done = count == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
    end else if (start) begin
      count <= CW'(WIDTH);
      dvd <= dividend;
      dvs <= divisor;
      rem <= '0;
    end else if (busy) begin
      count <= count - 1'b1;
      dvd <= quotient;
      rem <= remainder;
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; single-cycle arithmetic/compare, iterative div/mod
module seq_alu import alu_pkg::*; #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  seq_alu_if.slave bus
);
  localparam int RW = 2 * WIDTH;
  state_t state, state_d;
  logic [2:0] op;
  logic accept, start, load, dz_d, busy, done;
  logic [RW-1:0] ax, bx, quick, res_d;
  logic [WIDTH-1:0] quo, rem;
  assign bus.in_ready = state == ST_IDLE;
  assign bus.out_valid = state == ST_DONE;
  assign accept = bus.in_valid && bus.in_ready;
  assign ax = {{WIDTH{1'b0}}, bus.a};
  assign bx = {{WIDTH{1'b0}}, bus.b};
  // div/mod only reach this path with b==0
  assign quick = bus.opcode == OP_ADD ? ax + bx :
                 bus.opcode == OP_SUB ? ax - bx :
                 bus.opcode == OP_MUL ? ax * bx :
                 bus.opcode == OP_DIV ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} :
                 bus.opcode == OP_MOD ? ax :
                 bus.opcode == OP_EQ  ? {{(RW-1){1'b0}}, bus.a == bus.b} :
                 bus.opcode == OP_GT  ? {{(RW-1){1'b0}}, bus.a > bus.b} :
                                        {{(RW-1){1'b0}}, bus.a < bus.b};
  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(bus.a),
    .divisor(bus.b),
    .busy(busy),
    .done(done),
    .quotient(quo),
    .remainder(rem)
  );
  always_comb begin
    state_d = state;
    start = 1'b0;
    load = 1'b0;
    dz_d = 1'b0;
    res_d = quick;
    case (state)
      ST_IDLE:
        if (accept) begin
          start = is_divop(bus.opcode) && bus.b != '0;
          load = !start;
          dz_d = is_divop(bus.opcode);
          state_d = start ? ST_DIV : ST_DONE;
        end
      ST_DIV: begin
        load = done;
        res_d = {{WIDTH{1'b0}}, op == OP_DIV ? quo : rem};
        state_d = done ? ST_DONE : busy ? ST_DIV : ST_IDLE;
      end
      ST_DONE: state_d = bus.out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      op <= OP_ADD;
      bus.result <= '0;
      bus.div_zero <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) op <= bus.opcode;
      if (load) begin
        bus.result <= res_d;
        bus.div_zero <= dz_d;
        bus.zero <= res_d == '0;
      end
    end
endmodule
